bicubic_fetch: RTL and testbench

Upstream feeder for the bicubic interpolation core. For one target coordinate (integer pixel index plus 8-bit fraction), it:
- reads the four neighbouring pixels P(-1), P(0), P(1), P(2) from a single-port line memory, clamping at the row edges;
- computes the fractional power terms x, x², x³ in Q0.8 with one shared 8x8 multiplier;
- presents the complete operand set downstream on a valid/ready handshake.

---
 rtl/bicubic_fetch.sv | 157 +++++++++++++++
 tb/tb_bicubic_fetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_fetch.sv
// Operand fetch for the bicubic core: reads the 4-tap pixel neighbourhood with row-edge clamping
// and forms x, x^2, x^3 (Q0.8) on one shared multiplier, then offers the set on a valid/ready port.
module bicubic_fetch #(
    parameter int IMG_W = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] pos_int,
    input  logic [7:0]    pos_frac,
    output logic          busy,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_q,
    output logic [7:0]    p_m1,
    output logic [7:0]    p_0,
    output logic [7:0]    p_1,
    output logic [7:0]    p_2,
    output logic [7:0]    x_0,
    output logic [7:0]    x_1,
    output logic [7:0]    x_2,
    output logic [7:0]    x_3,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_OUT
    } state_t;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(IMG_W - 1);

    state_t        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic [AW-1:0] i_q, i_d;
    logic [7:0]    x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
    logic [7:0]    pm1_q, pm1_d, p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;

    logic [AW:0]   i_ext, i_inc1, i_inc2, addr_ext;
    logic [7:0]    mul_b, mul_res;
    logic [15:0]   mul_prod, mul_rnd;

    // k=0 squares x; k=1 reuses the same multiplier for x^2 * x.
    assign mul_b    = (k_q == 2'd0) ? x1_q : x2_q;
    assign mul_prod = 16'(x1_q) * 16'(mul_b);
    assign mul_rnd  = mul_prod + 16'd128;
    assign mul_res  = mul_rnd[15:8];

    assign i_ext  = {1'b0, i_q};
    assign i_inc1 = i_ext + (AW+1)'(1);
    assign i_inc2 = i_ext + (AW+1)'(2);

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        addr_ext = '0;
        case (k_q)
            2'd0: addr_ext = (i_q == '0) ? '0 : i_ext - (AW+1)'(1);
            2'd1: addr_ext = i_ext;
            2'd2: addr_ext = (i_inc1 > LAST_IDX) ? LAST_IDX : i_inc1;
            2'd3: addr_ext = (i_inc2 > LAST_IDX) ? LAST_IDX : i_inc2;
            default: addr_ext = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        x3_d    = x3_q;
        pm1_d   = pm1_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    i_d     = pos_int;
                    x1_d    = pos_frac;
                    k_d     = 2'd0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                k_d = k_q + 2'd1;
                // mem_q always holds the tap addressed one cycle earlier.
                case (k_q)
                    2'd0: x2_d = mul_res;
                    2'd1: begin
                        x3_d  = mul_res;
                        pm1_d = mem_q;
                    end
                    2'd2: p0_d = mem_q;
                    2'd3: begin
                        p1_d    = mem_q;
                        state_d = S_LAST;
                    end
                    default: ;
                endcase
            end
            S_LAST: begin
                p2_d    = mem_q;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            i_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            x3_q    <= '0;
            pm1_q   <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            x3_q    <= x3_d;
            pm1_q   <= pm1_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign mem_rd    = (state_q == S_READ);
    assign mem_addr  = mem_rd ? addr_ext[AW-1:0] : '0;
    assign out_valid = (state_q == S_OUT);
    assign p_m1      = pm1_q;
    assign p_0       = p0_q;
    assign p_1       = p1_q;
    assign p_2       = p2_q;
    assign x_0       = 8'hFF;
    assign x_1       = x1_q;
    assign x_2       = x2_q;
    assign x_3       = x3_q;

endmodule

// File: tb/tb_bicubic_fetch.sv
// Self-checking bench for bicubic_fetch: table vectors plus hand-written stall, back-to-back
// and reset sequences, all checked through an address queue and an operand scoreboard.
module tb_bicubic_fetch;

    localparam int IMG_W = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] pos_int = '0;
    logic [7:0]    pos_frac = '0;
    logic          out_ready = 1'b1;
    logic [7:0]    mem_q = '0;
    logic          busy, mem_rd, out_valid;
    logic [AW-1:0] mem_addr;
    logic [7:0]    p_m1, p_0, p_1, p_2, x_0, x_1, x_2, x_3;

    bicubic_fetch #(.IMG_W(IMG_W), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .pos_int(pos_int), .pos_frac(pos_frac),
        .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q),
        .p_m1(p_m1), .p_0(p_0), .p_1(p_1), .p_2(p_2),
        .x_0(x_0), .x_1(x_1), .x_2(x_2), .x_3(x_3),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Line memory: mem[a] = 3a+1, one-cycle read latency.
    always @(posedge clk) if (mem_rd) mem_q <= 8'(3 * int'(mem_addr) + 1);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [AW-1:0]       pos;
        logic [7:0]          frac;
        logic [3:0][AW-1:0]  addr;
        logic [3:0][7:0]     p;
        logic [7:0]          x1;
        logic [7:0]          x2;
        logic [7:0]          x3;
    } vec_t;

    vec_t          exp_q[$];
    int            launch_q[$];
    logic [AW-1:0] addr_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int pos, input int frac, input int a0, input int a1,
                                input int a2, input int a3, input int q0, input int q1,
                                input int q2, input int q3, input int x1, input int x2,
                                input int x3);
        vec_t v;
        v.pos = AW'(pos);  v.frac = 8'(frac);
        v.addr[0] = AW'(a0); v.addr[1] = AW'(a1); v.addr[2] = AW'(a2); v.addr[3] = AW'(a3);
        v.p[0] = 8'(q0); v.p[1] = 8'(q1); v.p[2] = 8'(q2); v.p[3] = 8'(q3);
        v.x1 = 8'(x1); v.x2 = 8'(x2); v.x3 = 8'(x3);
        return v;
    endfunction

    // Reference model for randomised requests.
    function automatic vec_t model(input int pos, input int frac);
        vec_t v;
        int a, t;
        v.pos = AW'(pos);
        v.frac = 8'(frac);
        for (int j = 0; j < 4; j++) begin
            a = pos + j - 1;
            if (a < 0) a = 0;
            if (a > IMG_W - 1) a = IMG_W - 1;
            v.addr[j] = AW'(a);
            v.p[j] = 8'(3 * a + 1);
        end
        v.x1 = 8'(frac);
        t = (frac * frac + 128) / 256;
        v.x2 = 8'(t);
        t = (t * frac + 128) / 256;
        v.x3 = 8'(t);
        return v;
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns one cycle later.
    task automatic issue(input vec_t v);
        start    = 1'b1;
        pos_int  = v.pos;
        pos_frac = v.frac;
        exp_q.push_back(v);
        launch_q.push_back(cyc);
        for (int j = 0; j < 4; j++) addr_q.push_back(v.addr[j]);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", 32'(busy), 0);
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!out_valid && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_valid", 32'(out_valid), 1);
    endtask

    // Monitor: checks addresses, latency, operands and the post-transfer cycle.
    logic prev_xfer  = 1'b0;
    logic seen_valid = 1'b0;
    vec_t cur;
    always @(negedge clk) begin
        if (rst) begin
            prev_xfer  = 1'b0;
            seen_valid = 1'b0;
        end else begin
            if (prev_xfer) begin
                check("valid_one_wide", 32'(out_valid), 0);
                check("idle_after_xfer", 32'(busy), 0);
            end
            prev_xfer = 1'b0;
            if (mem_rd) begin
                if (addr_q.size() == 0) check("unexpected_rd", 32'(mem_rd), 0);
                else check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(out_valid), 0);
                end else begin
                    cur = exp_q[0];
                    if (!seen_valid) begin
                        check("latency", 32'(cyc - launch_q[0]), 6);
                        seen_valid = 1'b1;
                    end
                    check("rd_in_out", 32'(mem_rd), 0);
                    check("busy_out", 32'(busy), 1);
                    check("p_m1", 32'(p_m1), 32'(cur.p[0]));
                    check("p_0", 32'(p_0), 32'(cur.p[1]));
                    check("p_1", 32'(p_1), 32'(cur.p[2]));
                    check("p_2", 32'(p_2), 32'(cur.p[3]));
                    check("x_0", 32'(x_0), 255);
                    check("x_1", 32'(x_1), 32'(cur.x1));
                    check("x_2", 32'(x_2), 32'(cur.x2));
                    check("x_3", 32'(x_3), 32'(cur.x3));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(launch_q.pop_front());
                        seen_valid = 1'b0;
                        prev_xfer  = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_mem_rd"}, 32'(mem_rd), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_p_m1"}, 32'(p_m1), 0);
        check({tag, "_p_0"}, 32'(p_0), 0);
        check({tag, "_p_1"}, 32'(p_1), 0);
        check({tag, "_p_2"}, 32'(p_2), 0);
        check({tag, "_x_0"}, 32'(x_0), 255);
        check({tag, "_x_1"}, 32'(x_1), 0);
        check({tag, "_x_2"}, 32'(x_2), 0);
        check({tag, "_x_3"}, 32'(x_3), 0);
    endtask

    vec_t tbl[5];
    vec_t v;
    int   c1, c2;

    initial begin
        tbl[0] = mk(10, 8'h80,  9, 10, 11, 12,  28, 31, 34, 37, 128,  64,  32);
        tbl[1] = mk( 0, 8'h00,  0,  0,  1,  2,   1,  1,  4,  7,   0,   0,   0);
        tbl[2] = mk(30, 8'hFF, 29, 30, 31, 31,  88, 91, 94, 94, 255, 254, 253);
        tbl[3] = mk( 5, 8'h40,  4,  5,  6,  7,  13, 16, 19, 22,  64,  16,   4);
        tbl[4] = mk(31, 8'h01, 30, 31, 31, 31,  91, 94, 94, 94,   1,   0,   0);

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst0");
        rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors, each issued as soon as the previous one retires.
        for (int n = 0; n < 5; n++) begin
            issue(tbl[n]);
            wait_idle(20);
        end

        // Back-to-back: second start lands exactly 7 cycles after the first.
        c1 = cyc;
        issue(tbl[0]);
        wait_idle(20);
        c2 = cyc;
        check("b2b_start_gap", 32'(c2 - c1), 7);
        issue(tbl[3]);
        wait_idle(20);

        // Back-pressure: hold off 5 cycles, pulse start during the stall and the handshake.
        out_ready = 1'b0;
        issue(model(17, 8'hC3));
        wait_valid(20);
        for (int s = 0; s < 5; s++) begin
            check("stall_busy", 32'(busy), 1);
            start   = (s % 2 == 0);
            pos_int = AW'(3);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("stall_release_idle", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("stall_start_ignored", 32'(busy), 0);

        // Reset in cycle 3 of a request, then a fresh request.
        issue(tbl[0]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        launch_q.delete();
        addr_q.delete();
        #1;
        check_reset_state("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(tbl[2]);
        wait_idle(20);

        // Random requests against the model.
        for (int r = 0; r < 6; r++) begin
            issue(model(int'($urandom_range(0, IMG_W - 1)), int'($urandom_range(0, 255))));
            wait_idle(20);
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size() + addr_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
